proc_control_fsm: RTL and testbench

Multi-cycle control unit for the 16-bit bus processor. It sits directly upstream of the bus multiplexer and drives that multiplexer's 11-bit one-hot source select. It also drives every register-load, ALU, PC and memory strobe in the datapath. It sequences fetch, decode and execute of one 9-bit instruction at a time.

---
 rtl/proc_ctrl_pkg.sv | 49 ++++
 rtl/ir_field_decode.sv | 22 ++
 rtl/proc_control_fsm.sv | 166 ++++++++++++++++
 tb/tb_proc_control_fsm.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the bus-processor control unit.
// Contents: state enum, opcode constants, bus_sel source indices, IR field
// positions, and a helper that maps a register one-hot onto bus_sel.
package proc_ctrl_pkg;

    typedef enum logic [2:0] {
        StFetch0,
        StFetch1,
        StDecode,
        StEx1,
        StEx2,
        StEx3
    } state_e;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    // bus_sel is declared [0:10]; these are its element indices
    localparam int unsigned SEL_DIN = 0;
    localparam int unsigned SEL_R0  = 1;
    localparam int unsigned SEL_R7  = 8;
    localparam int unsigned SEL_G   = 9;
    localparam int unsigned SEL_MEM = 10;

    localparam int unsigned OPC_MSB = 8;
    localparam int unsigned OPC_LSB = 6;
    localparam int unsigned RX_MSB  = 5;
    localparam int unsigned RX_LSB  = 3;
    localparam int unsigned RY_MSB  = 2;
    localparam int unsigned RY_LSB  = 0;

    // Place register one-hot bit i on bus_sel[SEL_R0 + i]; a plain slice
    // assignment would reverse the order because bus_sel is ascending.
    function automatic logic [0:10] reg_sel(input logic [7:0] oh);
        logic [0:10] sel;
        sel = '0;
        for (int i = 0; i < 8; i++) begin
            sel[SEL_R0 + i] = oh[i];
        end
        return sel;
    endfunction

endpackage

// File: rtl/ir_field_decode.sv
// Combinational IR field decoder.
// Ports:
//   ir     in  9  instruction word: [8:6] opcode, [5:3] Rx, [2:0] Ry
//   op_oh  out 8  one-hot opcode (bit n set for opcode n)
//   rx_oh  out 8  one-hot Rx register
//   ry_oh  out 8  one-hot Ry register
module ir_field_decode
    import proc_ctrl_pkg::*;
(
    input  logic [8:0] ir,
    output logic [7:0] op_oh,
    output logic [7:0] rx_oh,
    output logic [7:0] ry_oh
);

    always_comb begin
        op_oh = 8'b1 << ir[OPC_MSB:OPC_LSB];
        rx_oh = 8'b1 << ir[RX_MSB:RX_LSB];
        ry_oh = 8'b1 << ir[RY_MSB:RY_LSB];
    end

endmodule

// File: rtl/proc_control_fsm.sv
// Multi-cycle control unit for the 16-bit bus processor.
// Sequences fetch, decode and execute of one 9-bit instruction at a time and
// drives the bus mux select plus every datapath strobe.
// Ports:
//   Clock, Resetn       clock (rising edge), async active-low reset
//   Run                 allows the next fetch (sampled in FETCH0 only)
//   ir [8:0]            current instruction from IR
//   g_nz                G register non-zero flag (used by mvnz)
//   bus_sel [0:10]      one-hot bus source: 0=DIN, 1..8=R0..R7, 9=G, 10=MEM
//   r_in [7:0]          one-hot R0..R7 load enable
//   a_in, g_in, ir_in   A, G, IR load enables
//   add_sub             ALU op: 0=add, 1=sub
//   addr_in, dout_in    memory address / write-data register loads
//   w_d                 memory write strobe
//   incr_pc             increment R7
//   done                last step of the instruction
module proc_control_fsm
    import proc_ctrl_pkg::*;
(
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Run,
    input  logic [8:0]  ir,
    input  logic        g_nz,
    output logic [0:10] bus_sel,
    output logic [7:0]  r_in,
    output logic        a_in,
    output logic        g_in,
    output logic        ir_in,
    output logic        add_sub,
    output logic        addr_in,
    output logic        dout_in,
    output logic        w_d,
    output logic        incr_pc,
    output logic        done
);

    state_e     state_q, state_d;
    logic [7:0] op_oh, rx_oh, ry_oh;
    logic       short_op;

    ir_field_decode u_ir_decode (
        .ir    (ir),
        .op_oh (op_oh),
        .rx_oh (rx_oh),
        .ry_oh (ry_oh)
    );

    // Instructions that complete in EX1
    assign short_op = op_oh[OP_MV] | op_oh[OP_MVNZ] | op_oh[OP_NOP];

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= StFetch0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch0: state_d = Run ? StFetch1 : StFetch0;
            StFetch1: state_d = StDecode;
            StDecode: state_d = StEx1;
            StEx1:    state_d = short_op ? StFetch0 : StEx2;
            StEx2:    state_d = StEx3;
            StEx3:    state_d = StFetch0;
            default:  state_d = StFetch0;
        endcase
    end

    // Outputs are gated by Resetn so that a reset asserted with Run=1 cannot
    // leak the FETCH0 strobes while the state register is held.
    always_comb begin
        bus_sel = '0;
        r_in    = '0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        ir_in   = 1'b0;
        add_sub = 1'b0;
        addr_in = 1'b0;
        dout_in = 1'b0;
        w_d     = 1'b0;
        incr_pc = 1'b0;
        done    = 1'b0;
        if (Resetn) begin
            unique case (state_q)
                StFetch0: begin
                    if (Run) begin
                        bus_sel[SEL_R7] = 1'b1;
                        addr_in         = 1'b1;
                        incr_pc         = 1'b1;
                    end
                end
                StDecode: ir_in = 1'b1;
                StEx1: begin
                    unique case (1'b1)
                        op_oh[OP_MV]: begin
                            bus_sel = reg_sel(ry_oh);
                            r_in    = rx_oh;
                            done    = 1'b1;
                        end
                        op_oh[OP_MVI]: begin
                            bus_sel[SEL_R7] = 1'b1;
                            addr_in         = 1'b1;
                            incr_pc         = 1'b1;
                        end
                        op_oh[OP_ADD], op_oh[OP_SUB]: begin
                            bus_sel = reg_sel(rx_oh);
                            a_in    = 1'b1;
                        end
                        op_oh[OP_LD], op_oh[OP_ST]: begin
                            bus_sel = reg_sel(ry_oh);
                            addr_in = 1'b1;
                        end
                        op_oh[OP_MVNZ]: begin
                            done = 1'b1;
                            if (g_nz) begin
                                bus_sel = reg_sel(ry_oh);
                                r_in    = rx_oh;
                            end
                        end
                        op_oh[OP_NOP]: done = 1'b1;
                        default: ;
                    endcase
                end
                StEx2: begin
                    unique case (1'b1)
                        op_oh[OP_ADD], op_oh[OP_SUB]: begin
                            bus_sel = reg_sel(ry_oh);
                            g_in    = 1'b1;
                            add_sub = op_oh[OP_SUB];
                        end
                        op_oh[OP_ST]: begin
                            bus_sel = reg_sel(rx_oh);
                            dout_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                StEx3: begin
                    unique case (1'b1)
                        op_oh[OP_MVI], op_oh[OP_LD]: begin
                            bus_sel[SEL_MEM] = 1'b1;
                            r_in             = rx_oh;
                            done             = 1'b1;
                        end
                        op_oh[OP_ADD], op_oh[OP_SUB]: begin
                            bus_sel[SEL_G] = 1'b1;
                            r_in           = rx_oh;
                            done           = 1'b1;
                        end
                        op_oh[OP_ST]: begin
                            w_d  = 1'b1;
                            done = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_control_fsm.sv
// Self-checking bench for proc_control_fsm: directed cases plus a random
// instruction stream, checked against a per-step instruction table model.
module tb_proc_control_fsm;

    logic        Clock;
    logic        Resetn;
    logic        Run;
    logic [8:0]  ir;
    logic        g_nz;
    logic [0:10] bus_sel;
    logic [7:0]  r_in;
    logic        a_in, g_in, ir_in, add_sub, addr_in, dout_in, w_d, incr_pc, done;

    int n_checks = 0;
    int n_pass   = 0;

    proc_control_fsm dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .Run     (Run),
        .ir      (ir),
        .g_nz    (g_nz),
        .bus_sel (bus_sel),
        .r_in    (r_in),
        .a_in    (a_in),
        .g_in    (g_in),
        .ir_in   (ir_in),
        .add_sub (add_sub),
        .addr_in (addr_in),
        .dout_in (dout_in),
        .w_d     (w_d),
        .incr_pc (incr_pc),
        .done    (done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [27:0] got, input logic [27:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [27:0] observed();
        return {bus_sel, r_in, a_in, g_in, ir_in, add_sub, addr_in, dout_in, w_d, incr_pc, done};
    endfunction

    // src: bus source index (-1 = none); remaining args are the strobes in
    // the same order as observed()
    function automatic logic [27:0] pack_out(input int src, input logic [7:0] rin,
                                             input logic a, input logic g, input logic iri,
                                             input logic asub, input logic addr,
                                             input logic dout, input logic wd,
                                             input logic inc, input logic dn);
        logic [0:10] b;
        b = '0;
        if (src >= 0) b[src] = 1'b1;
        return {b, rin, a, g, iri, asub, addr, dout, wd, inc, dn};
    endfunction

    function automatic int instr_len(input int op);
        return (op == 0 || op == 6 || op == 7) ? 4 : 6;
    endfunction

    // Expected outputs for step `step` (0 = fetch cycle) of instruction op
    function automatic logic [27:0] model(input int op, input int rx, input int ry,
                                          input logic gnz, input int step);
        logic [7:0] rxo;
        rxo = 8'd1 << rx;
        case (step)
            0: return pack_out(8, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
            1: return '0;
            2: return pack_out(-1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
            3: case (op)
                0: return pack_out(1 + ry, rxo, 0, 0, 0, 0, 0, 0, 0, 0, 1);
                1: return pack_out(8, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
                2, 3: return pack_out(1 + rx, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
                4, 5: return pack_out(1 + ry, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
                6: return gnz ? pack_out(1 + ry, rxo, 0, 0, 0, 0, 0, 0, 0, 0, 1)
                              : pack_out(-1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
                default: return pack_out(-1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            endcase
            4: case (op)
                2, 3: return pack_out(1 + ry, 0, 0, 1, 0, (op == 3), 0, 0, 0, 0, 0);
                5: return pack_out(1 + rx, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
                default: return '0;
            endcase
            5: case (op)
                1, 4: return pack_out(10, rxo, 0, 0, 0, 0, 0, 0, 0, 0, 1);
                2, 3: return pack_out(9, rxo, 0, 0, 0, 0, 0, 0, 0, 0, 1);
                5: return pack_out(-1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
                default: return '0;
            endcase
            default: return '0;
        endcase
    endfunction

    task automatic check_invariants(input string tag);
        check_eq({tag, "/bus_onehot"}, 28'($countones(bus_sel) <= 1), 28'd1);
        check_eq({tag, "/rin_onehot"}, 28'($countones(r_in) <= 1), 28'd1);
        check_eq({tag, "/pc_r7"}, 28'(!(incr_pc && r_in[7])), 28'd1);
    endtask

    // Entered #1 after a posedge with the DUT in FETCH0. IR and g_nz carry
    // noise until the cycles where the model says they matter.
    task automatic run_instr(input int op, input int rx, input int ry, input logic gnz,
                             input int max_step);
        for (int step = 0; step < instr_len(op) && step <= max_step; step++) begin
            if (step < 3) ir = 9'($urandom);
            else          ir = 9'({op[2:0], rx[2:0], ry[2:0]});
            g_nz = (step == 3) ? gnz : 1'($urandom);
            Run  = (step == 0) ? 1'b1 : 1'($urandom);
            @(negedge Clock);
            check_eq($sformatf("op%0d_rx%0d_ry%0d_g%0d_step%0d", op, rx, ry, gnz, step),
                     observed(), model(op, rx, ry, gnz, step));
            check_invariants($sformatf("op%0d_step%0d", op, step));
            if (step < max_step) begin
                @(posedge Clock);
                #1;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            Run  = 1'b0;
            ir   = 9'($urandom);
            g_nz = 1'($urandom);
            @(negedge Clock);
            check_eq($sformatf("idle%0d", i), observed(), '0);
            @(posedge Clock);
            #1;
        end
    endtask

    initial begin
        Resetn = 1'b0;
        Run    = 1'b1;
        ir     = 9'b0;
        g_nz   = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        check_eq("reset_outputs", observed(), '0);
        Run    = 1'b0;
        Resetn = 1'b1;

        idle_cycles(10);

        run_instr(0, 3, 5, 1'b0, 99);   // mv R3,R5
        run_instr(3, 1, 2, 1'b1, 99);   // sub R1,R2
        run_instr(5, 4, 6, 1'b0, 99);   // st R4,[R6]
        run_instr(6, 0, 1, 1'b0, 99);   // mvnz, G zero
        run_instr(6, 0, 1, 1'b1, 99);   // mvnz, G non-zero
        run_instr(2, 7, 7, 1'b0, 99);   // add R7,R7
        run_instr(1, 7, 0, 1'b0, 99);   // mvi R7
        run_instr(4, 2, 7, 1'b0, 99);   // ld R2,[R7]
        run_instr(7, 0, 0, 1'b1, 99);   // nop

        // Abort an add in EX2 with an asynchronous reset
        run_instr(2, 5, 6, 1'b0, 4);
        #2;
        Resetn = 1'b0;
        #1;
        check_eq("reset_async_ex2", observed(), '0);
        @(posedge Clock);
        #1;
        check_eq("reset_held", observed(), '0);
        Resetn = 1'b1;
        run_instr(2, 5, 6, 1'b0, 99);   // first fetch right after release

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0) idle_cycles(1);
            run_instr(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)), 1'($urandom), 99);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
